posx_tracker: RTL

//  Receive side of the 2-bit horizontal step command (2'b10 = +1, 2'b01 = -1).

---
 rtl/posx_pkg.sv | 15 +
 rtl/step_tick_gen.sv | 25 ++
 rtl/posx_tracker.sv | 95 +++++++++
 3 files changed

// File: rtl/posx_pkg.sv
// posx_pkg: shared command codes and state encoding for the X-position tracker.
package posx_pkg;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_DEC = 2'b01;
    localparam logic [1:0] CMD_INC = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FROZEN = 2'b10
    } state_t;

endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen: prescaler emitting a one-cycle tick every STEP_DIV enabled cycles.
// The count is held at zero whenever en is low.
module step_tick_gen #(
    parameter int STEP_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = en && cnt_q == LAST;
    assign cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/posx_tracker.sv
// posx_tracker: bounded X position with step tick and one-shot MIN/MAX pulses.
// Optional illegal-command counter on err_cnt when POSX_ILLEGAL_CNT_EN is defined.
module posx_tracker
    import posx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MIN      = 0,
    parameter int MAX      = 159,
    parameter int STEP_DIV = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sta,
    input  logic             perdio,
    input  logic             ld,
    input  logic [1:0]       i_signal,
    output logic             s,
    output logic             MN,
    output logic             MX,
    output logic [WIDTH-1:0] pos
`ifdef POSX_ILLEGAL_CNT_EN
   ,output logic [3:0]       err_cnt
`endif
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] CTR_V = WIDTH'((MIN + MAX) / 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             mn_q, mn_d, mx_q, mx_d;
    logic             arm_min_q, arm_min_d, arm_max_q, arm_max_d;
    logic             run, move;

    assign run  = state_q == ST_RUN;
    // ld and perdio both discard the command in their cycle
    assign move = run && !ld && !perdio && i_signal != CMD_NOP && i_signal != CMD_ILL;

    step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .tick (s)
    );

    always_comb begin
        state_d   = ld ? state_q :
                    (state_q == ST_IDLE && sta) ? ST_RUN :
                    (run && perdio) ? ST_FROZEN : state_q;
        pos_d     = ld ? CTR_V :
                    !move ? pos_q :
                    i_signal == CMD_INC ? (pos_q == MAX_V ? pos_q : pos_q + 1'b1) :
                    (pos_q == MIN_V ? pos_q : pos_q - 1'b1);
        mx_d      = !ld && arm_max_q && pos_d == MAX_V;
        mn_d      = !ld && arm_min_q && pos_d == MIN_V;
        arm_max_d = ld || pos_d != MAX_V;
        arm_min_d = ld || pos_d != MIN_V;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pos_q     <= CTR_V;
            mn_q      <= 1'b0;
            mx_q      <= 1'b0;
            arm_min_q <= 1'b1;
            arm_max_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            mn_q      <= mn_d;
            mx_q      <= mx_d;
            arm_min_q <= arm_min_d;
            arm_max_q <= arm_max_d;
        end
    end

    assign pos = pos_q;
    assign MN  = mn_q;
    assign MX  = mx_q;

`ifdef POSX_ILLEGAL_CNT_EN
    logic [3:0] err_q, err_d;

    assign err_d   = (run && i_signal == CMD_ILL && err_q != 4'hF) ? err_q + 4'd1 : err_q;
    assign err_cnt = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 4'd0;
        else      err_q <= err_d;
    end
`endif

endmodule
